mult_div_unit: RTL and testbench

//   HI/LO multiply-divide unit for the MIPS datapath. Executes mult/multu/div/divu

---
 rtl/mult_div_unit_if.sv | 29 ++
 rtl/mult_div_unit.sv | 139 +++++++++++++
 tb/tb_mult_div_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_if
// Description : Request/result bundle between the datapath and the HI/LO
//               multiply-divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en;
    logic        wr_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, wr_en, wr_sel,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, wr_en, wr_sel,
        output busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : MIPS HI/LO multiply-divide unit with fixed-latency operations
//               and mthi/mtlo writes.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mult_div_unit_if.slave    bus
);

    localparam int C_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int C_CNT_W      = $clog2(C_MAX_CYCLES + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]         state_q,  state_d;
    logic [C_CNT_W-1:0] cnt_q,    cnt_d;
    logic [31:0]        hi_q,     hi_d;
    logic [31:0]        lo_q,     lo_d;
    logic [31:0]        res_hi_q, res_hi_d;
    logic [31:0]        res_lo_q, res_lo_d;
    logic               commit_q, commit_d;

    // Arithmetic on the live operands; the result is captured at the start edge.
    logic        w_is_signed;
    logic        w_is_div;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_den;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_zero;

    always_comb begin
        w_is_signed = ~bus.op[0];
        w_is_div    = bus.op[1];
        w_mul_a     = {{32{w_is_signed & bus.rs_data[31]}}, bus.rs_data};
        w_mul_b     = {{32{w_is_signed & bus.rt_data[31]}}, bus.rt_data};
        w_prod      = w_mul_a * w_mul_b;

        // Signed division via magnitudes: quotient truncates toward zero,
        // remainder follows the dividend. 0x80000000 / -1 falls out naturally.
        w_neg_a     = w_is_signed & bus.rs_data[31];
        w_neg_b     = w_is_signed & bus.rt_data[31];
        w_mag_a     = w_neg_a ? (~bus.rs_data + 32'd1) : bus.rs_data;
        w_mag_b     = w_neg_b ? (~bus.rt_data + 32'd1) : bus.rt_data;
        w_div_zero  = (bus.rt_data == 32'd0);
        w_den       = w_div_zero ? 32'd1 : w_mag_b;
        w_uq        = w_mag_a / w_den;
        w_ur        = w_mag_a % w_den;
        w_quot      = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
        w_rem       = w_neg_a ? (~w_ur + 32'd1) : w_ur;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            commit_q <= commit_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == C_CNT_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        commit_d = commit_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d    = w_is_div ? C_CNT_W'(DIV_CYCLES) : C_CNT_W'(MULT_CYCLES);
                    res_hi_d = w_is_div ? w_rem  : w_prod[63:32];
                    res_lo_d = w_is_div ? w_quot : w_prod[31:0];
                    commit_d = ~(w_is_div & w_div_zero);
                end else if (bus.wr_en) begin
                    if (bus.wr_sel) hi_d = bus.rs_data;
                    else            lo_d = bus.rs_data;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - C_CNT_W'(1);
                if (cnt_q == C_CNT_W'(1) && commit_q) begin
                    hi_d = res_hi_q;
                    lo_d = res_lo_q;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy = (state_q == S_BUSY);
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed scoreboard bench for the HI/LO multiply-divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk;
    logic reset;
    mult_div_unit_if bus_if ();

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          checks;
    int          failures;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse and push the expected outcome.
    task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input bit commit);
        exp_t e;
        e.tag    = tag;
        e.hi     = commit ? eh : model_hi;
        e.lo     = commit ? el : model_lo;
        e.cycles = op[1] ? DIV_N : MULT_N;
        sb.push_back(e);
        bus_if.start   = 1'b1;
        bus_if.op      = op;
        bus_if.rs_data = a;
        bus_if.rt_data = b;
        @(negedge clk);
        bus_if.start   = 1'b0;
    endtask

    // Count busy cycles, verify hi/lo hold, then compare against the scoreboard.
    task automatic wait_done(input int pre);
        exp_t e;
        int   n;
        n = pre;
        while (bus_if.busy === 1'b1 && n < 64) begin
            n++;
            check("hold_hi", bus_if.hi, model_hi);
            check("hold_lo", bus_if.lo, model_lo);
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            check({e.tag, "_busy_cycles"}, 32'(n), 32'(e.cycles));
            check({e.tag, "_hi"}, bus_if.hi, e.hi);
            check({e.tag, "_lo"}, bus_if.lo, e.lo);
            model_hi = e.hi;
            model_lo = e.lo;
        end
    endtask

    task automatic mt(input bit sel, input logic [31:0] d);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_sel  = sel;
        bus_if.rs_data = d;
        @(negedge clk);
        bus_if.wr_en   = 1'b0;
        if (sel) model_hi = d;
        else     model_lo = d;
        check(sel ? "mthi" : "mtlo", sel ? bus_if.hi : bus_if.lo, d);
        check("mt_busy", 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        checks   = 0;
        failures = 0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        reset          = 1'b0;
        bus_if.start   = 1'b0;
        bus_if.op      = 2'b00;
        bus_if.rs_data = 32'd0;
        bus_if.rt_data = 32'd0;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_sel  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("reset_busy", 32'(bus_if.busy), 32'd0);
        check("reset_hi", bus_if.hi, 32'd0);
        check("reset_lo", bus_if.lo, 32'd0);

        issue("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        wait_done(0);
        issue("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        wait_done(0);
        issue("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        wait_done(0);
        issue("divu_7_2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b1);
        wait_done(0);
        issue("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b1);
        wait_done(0);
        issue("div_rem_neg", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b1);
        wait_done(0);

        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        issue("div_zero", 2'b10, 32'd1234, 32'd0, 32'd0, 32'd0, 1'b0);
        wait_done(0);

        // start and wr_en together in IDLE: the write must be dropped
        bus_if.wr_en  = 1'b1;
        bus_if.wr_sel = 1'b0;
        issue("start_wins", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);
        bus_if.wr_en  = 1'b0;
        wait_done(0);

        // mthi and a second start during BUSY are both ignored
        issue("busy_ignore", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);
        check("busy_cycle1", 32'(bus_if.busy), 32'd1);
        bus_if.start   = 1'b1;
        bus_if.op      = 2'b11;
        bus_if.rs_data = 32'hAB;
        bus_if.rt_data = 32'd5;
        bus_if.wr_en   = 1'b1;
        bus_if.wr_sel  = 1'b1;
        @(negedge clk);
        bus_if.start   = 1'b0;
        bus_if.wr_en   = 1'b0;
        wait_done(1);
        mt(1'b0, 32'hCD);
        check("mtlo_keeps_hi", bus_if.hi, 32'd0);

        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            p = {32'd0, a} * {32'd0, b};
            issue("multu_rand", 2'b01, a, b, p[63:32], p[31:0], 1'b1);
            wait_done(0);
            b = b >> (i * 8);
            if (b == 32'd0) b = 32'd3;
            issue("divu_rand", 2'b11, a, b, a % b, a / b, 1'b1);
            wait_done(0);
        end

        // Reset in the 4th busy cycle of a div aborts it
        issue("div_abort", 2'b10, 32'd100, 32'd7, 32'd0, 32'd0, 1'b1);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_hi = 32'd0;
        model_lo = 32'd0;
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        check("abort_hi", bus_if.hi, 32'd0);
        check("abort_lo", bus_if.lo, 32'd0);
        issue("after_reset", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b1);
        check("after_reset_busy", 32'(bus_if.busy), 32'd1);
        wait_done(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
